// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the memory port arbiter: default widths, memory
// command encodings, arbiter state encodings and requester identities.
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned MASK_W      = 4;
  localparam int unsigned TIMEOUT_DEF = 64;

  // Memory / dcache command encoding (11 is illegal and treated as idle)
  typedef enum logic [1:0] {
    RW_IDLE  = 2'b00,
    RW_READ  = 2'b01,
    RW_WRITE = 2'b10,
    RW_ILL   = 2'b11
  } rw_e;

  // Arbiter state encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_BUSY_I = 2'b01,
    ST_BUSY_D = 2'b10
  } arb_state_e;

  // Requester identity; bit position in the request vector matches the value
  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  // A dcache command is a request only for a legal read or write
  function automatic logic rw_is_req(input logic [1:0] rw);
    return (rw == RW_READ) || (rw == RW_WRITE);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Two-way round-robin chooser. A lone requester is granted; when both
// request, the one that was not granted last wins.
// Ports:
//   req_i   [1:0]  request vector (bit index = requester id)
//   last_i         id of the requester granted most recently
//   grant_o [1:0]  one-hot grant (zero when nobody requests)
// ---------------------------------------------------------------------------
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one external memory port between the instruction cache (read only)
// and the data cache (read/write). Round-robin arbitration in IDLE, request
// fields latched at grant and held until the memory completes, and a
// watchdog that bounds each transaction and raises a sticky error.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_req/i_addr             icache read request (level) and address
//   i_done/i_rdata           icache completion pulse and read data
//   d_rw/d_addr/d_wdata/d_mask  dcache command, address, write data, mask
//   d_done/d_rdata           dcache completion pulse and read data
//   m_rw/m_addr/m_wdata/m_mask  registered memory command
//   m_rd_valid/m_wr_done/m_rdata  memory completion pulses and read data
//   err                      sticky watchdog timeout flag
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  // icache side
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  // dcache side
  input  logic [1:0]        d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [MASK_W-1:0] d_mask,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  // memory side
  output logic [1:0]        m_rw,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [MASK_W-1:0] m_mask,
  input  logic              m_rd_valid,
  input  logic              m_wr_done,
  input  logic [DATA_W-1:0] m_rdata,
  // status
  output logic              err
);

  localparam int unsigned WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  arb_state_e         state_q;
  owner_e             last_q;
  logic [1:0]         m_rw_q;
  logic [ADDR_W-1:0]  m_addr_q;
  logic [DATA_W-1:0]  m_wdata_q;
  logic [MASK_W-1:0]  m_mask_q;
  logic [WD_W-1:0]    wd_q;
  logic               err_q;
  logic [DATA_W-1:0]  i_rdata_q;
  logic [DATA_W-1:0]  d_rdata_q;

  logic [1:0]         req_vec;
  logic [1:0]         grant;
  logic               busy_c;
  logic               cmpl_c;
  logic               tmo_c;
  logic               fin_c;
  logic               upd_rdata_c;
  logic [DATA_W-1:0]  new_rdata_c;

  // Request vector: bit 0 icache, bit 1 dcache (illegal d_rw is no request)
  assign req_vec = {rw_is_req(d_rw), i_req};

  rr_pick2 u_pick (
    .req_i   (req_vec),
    .last_i  (last_q),
    .grant_o (grant)
  );

  // Completion / timeout decode for the transaction in flight
  always_comb begin
    busy_c      = (state_q != ST_IDLE);
    // only the pulse matching the latched op counts; the other is ignored
    cmpl_c      = busy_c && ((m_rw_q == RW_WRITE) ? m_wr_done : m_rd_valid);
    // a completion in the last watchdog cycle wins over the timeout
    tmo_c       = busy_c && !cmpl_c && (wd_q == WD_LAST);
    // reset aborts silently, so no done pulse while rst is high
    fin_c       = (cmpl_c || tmo_c) && !rst;
    // read data is captured on read completion; a timeout forces zero
    upd_rdata_c = fin_c && (tmo_c || (m_rw_q == RW_READ));
    new_rdata_c = cmpl_c ? m_rdata : '0;
  end

  // Done pulses pass straight through, gated by the current owner
  assign i_done  = fin_c && (state_q == ST_BUSY_I);
  assign d_done  = fin_c && (state_q == ST_BUSY_D);
  assign i_rdata = (i_done && upd_rdata_c) ? new_rdata_c : i_rdata_q;
  assign d_rdata = (d_done && upd_rdata_c) ? new_rdata_c : d_rdata_q;

  assign m_rw    = m_rw_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_mask  = m_mask_q;
  assign err     = err_q;

  // Arbiter FSM with registered memory command, watchdog and read data
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_q    <= OWNER_I;
      m_rw_q    <= RW_IDLE;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_mask_q  <= '0;
      wd_q      <= '0;
      err_q     <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          wd_q <= '0;
          if (grant[OWNER_D]) begin
            m_rw_q    <= d_rw;
            m_addr_q  <= d_addr;
            m_wdata_q <= d_wdata;
            m_mask_q  <= (d_rw == RW_WRITE) ? d_mask : '0;
            last_q    <= OWNER_D;
            state_q   <= ST_BUSY_D;
          end else if (grant[OWNER_I]) begin
            m_rw_q    <= RW_READ;
            m_addr_q  <= i_addr;
            m_wdata_q <= '0;
            m_mask_q  <= '0;
            last_q    <= OWNER_I;
            state_q   <= ST_BUSY_I;
          end
        end

        ST_BUSY_I, ST_BUSY_D: begin
          if (fin_c) begin
            // drop the command for at least one idle cycle on the port
            m_rw_q  <= RW_IDLE;
            state_q <= ST_IDLE;
            if (tmo_c) begin
              err_q <= 1'b1;
            end
            if (upd_rdata_c) begin
              if (state_q == ST_BUSY_I) begin
                i_rdata_q <= new_rdata_c;
              end else begin
                d_rdata_q <= new_rdata_c;
              end
            end
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end

        default: begin
          state_q <= ST_IDLE;
          m_rw_q  <= RW_IDLE;
        end
      endcase
    end
  end

endmodule
